// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC seven-segment scanner.
package rtc_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_HRM  = 3'd0;
  localparam logic [2:0] IDX_HRL  = 3'd1;
  localparam logic [2:0] IDX_MINM = 3'd2;
  localparam logic [2:0] IDX_MINL = 3'd3;
  localparam logic [2:0] IDX_SECM = 3'd4;
  localparam logic [2:0] IDX_SECL = 3'd5;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/rtc_seg_scan_if.sv
// RTC digit bus: six BCD digits plus the scan enable.
interface rtc_seg_scan_if;

  logic       en;
  logic [3:0] hrm;
  logic [3:0] hrl;
  logic [3:0] minm;
  logic [3:0] minl;
  logic [3:0] secm;
  logic [3:0] secl;

  modport master (
    output en, hrm, hrl,
    output minm, minl, secm, secl
  );

  modport slave (
    input en, hrm, hrl,
    input minm, minl, secm, secl
  );

endinterface

// File: rtl/rtc_seg_scan_bcd.sv
// BCD to seven-segment decoder; codes 10..15 render as a dash.
module bcd_to_seg
  import rtc_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/rtc_seg_scan.sv
// Six-digit multiplexed display scanner with per-frame digit snapshot.
// Optional macro RTC_SEG_BLINK_EN blinks the separators every 32 frames.
module rtc_seg_scan
  import rtc_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [5:0] dig_o,
  output logic       frame_o
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(SCAN_DIV - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] snap_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d;
  snap_t         live;
  logic          frame_q, frame_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    dig_q, dig_d;
  logic [3:0]    cur;
  logic [6:0]    dec_seg;
  logic          blank;

`ifdef RTC_SEG_BLINK_EN
  logic [5:0]    fcnt_q, fcnt_d;
`endif

  // Entry 0 holds hrm so the scan index addresses it directly.
  assign live = {secl, secm, minl, minm, hrl, hrm};

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
`ifdef RTC_SEG_BLINK_EN
    fcnt_d  = fcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        pre_d = '0;
        idx_d = IDX_HRM;
        if (en) begin
          state_d = SCAN;
          snap_d  = live;
          frame_d = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          pre_d   = '0;
          idx_d   = IDX_HRM;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (idx_q == IDX_SECL) begin
            idx_d   = IDX_HRM;
            snap_d  = live;
            frame_d = 1'b1;
`ifdef RTC_SEG_BLINK_EN
            // Counts completed frames.
            fcnt_d  = fcnt_q + 6'd1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur = snap_q[0];
    case (idx_q)
      IDX_HRM:  cur = snap_q[0];
      IDX_HRL:  cur = snap_q[1];
      IDX_MINM: cur = snap_q[2];
      IDX_MINL: cur = snap_q[3];
      IDX_SECM: cur = snap_q[4];
      IDX_SECL: cur = snap_q[5];
      default:  cur = snap_q[0];
    endcase
  end

  bcd_to_seg u_dec (
    .bcd_i (cur),
    .seg_o (dec_seg)
  );

  assign blank = LZ_BLANK
    && (idx_q == IDX_HRM)
    && (snap_q[0] == 4'd0);

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    dig_d = '0;
    if (state_q == SCAN) begin
      dig_d = 6'b100000 >> idx_q;
      seg_d = blank ? 7'd0 : dec_seg;
      dp_d  = (idx_q == IDX_HRL)
           || (idx_q == IDX_MINL);
`ifdef RTC_SEG_BLINK_EN
      dp_d  = dp_d & ~fcnt_q[5];
`endif
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      idx_q   <= IDX_HRM;
      snap_q  <= '0;
      frame_q <= 1'b0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

`ifdef RTC_SEG_BLINK_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end
`endif

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_rtc_seg_scan.sv
// Bench for rtc_seg_scan: two instances (SCAN_DIV 4 and 1) against
// a frame/slot arithmetic model. Honours RTC_SEG_BLINK_EN.
module tb_rtc_seg_scan;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rtc_seg_scan_if bus ();

  logic [6:0] seg_w   [2];
  logic       dp_w    [2];
  logic [5:0] dig_w   [2];
  logic       frame_w [2];

  rtc_seg_scan #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut0 (
    .clkin   (clk),
    .rst     (rst),
    .en      (bus.en),
    .hrm     (bus.hrm),
    .hrl     (bus.hrl),
    .minm    (bus.minm),
    .minl    (bus.minl),
    .secm    (bus.secm),
    .secl    (bus.secl),
    .seg_o   (seg_w[0]),
    .dp_o    (dp_w[0]),
    .dig_o   (dig_w[0]),
    .frame_o (frame_w[0])
  );

  rtc_seg_scan #(.SCAN_DIV(1), .LZ_BLANK(1'b1)) dut1 (
    .clkin   (clk),
    .rst     (rst),
    .en      (bus.en),
    .hrm     (bus.hrm),
    .hrl     (bus.hrl),
    .minm    (bus.minm),
    .minl    (bus.minl),
    .secm    (bus.secm),
    .secl    (bus.secl),
    .seg_o   (seg_w[1]),
    .dp_o    (dp_w[1]),
    .dig_o   (dig_w[1]),
    .frame_o (frame_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         DIV [2] = '{4, 1};
  logic [6:0] segtab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40,
    7'h40, 7'h40, 7'h40, 7'h40
  };

  // Model: running flag, cycles since entry, frames done, snapshot.
  bit         mrun [2];
  int         mk   [2];
  int         mfr  [2];
  logic [3:0] msnap[2][6];

  task automatic chk(string tag, logic [7:0] obs,
                     logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mrun[u] = 1'b0;
      mk[u]   = 0;
      mfr[u]  = 0;
      for (int d = 0; d < 6; d++) msnap[u][d] = 4'd0;
    end
  endtask

  task automatic chk_dark(string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_seg%0d", tag, u),
          {1'b0, seg_w[u]}, 8'h00);
      chk($sformatf("%s_dig%0d", tag, u),
          {2'b0, dig_w[u]}, 8'h00);
      chk($sformatf("%s_dp%0d", tag, u),
          {7'b0, dp_w[u]}, 8'h00);
      chk($sformatf("%s_frm%0d", tag, u),
          {7'b0, frame_w[u]}, 8'h00);
    end
  endtask

  task automatic tick();
    logic [3:0] live [6];
    logic       en_s;
    en_s    = bus.en;
    live[0] = bus.hrm;
    live[1] = bus.hrl;
    live[2] = bus.minm;
    live[3] = bus.minl;
    live[4] = bus.secm;
    live[5] = bus.secl;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      int         slot;
      logic [6:0] es;
      logic [5:0] ed;
      logic       edp;
      logic       efr;
      es   = '0;
      ed   = '0;
      edp  = 1'b0;
      efr  = 1'b0;
      slot = 0;
      if (mrun[u]) begin
        slot = (mk[u] / DIV[u]) % 6;
        ed   = 6'b100000 >> slot;
        if (slot == 0 && msnap[u][0] == 4'd0)
          es = 7'd0;
        else
          es = segtab[msnap[u][slot]];
        edp = (slot == 1) || (slot == 3);
`ifdef RTC_SEG_BLINK_EN
        if ((mfr[u] % 64) >= 32) edp = 1'b0;
`endif
      end
      if (mrun[u]) begin
        if (!en_s) begin
          mrun[u] = 1'b0;
        end else begin
          mk[u]++;
          if (mk[u] % (6 * DIV[u]) == 0) begin
            for (int d = 0; d < 6; d++)
              msnap[u][d] = live[d];
            efr = 1'b1;
            mfr[u]++;
          end
        end
      end else if (en_s) begin
        mrun[u] = 1'b1;
        mk[u]   = 0;
        for (int d = 0; d < 6; d++)
          msnap[u][d] = live[d];
        efr = 1'b1;
      end
      chk($sformatf("seg%0d", u),
          {1'b0, seg_w[u]}, {1'b0, es});
      chk($sformatf("dig%0d", u),
          {2'b0, dig_w[u]}, {2'b0, ed});
      chk($sformatf("dp%0d", u),
          {7'b0, dp_w[u]}, {7'b0, edp});
      chk($sformatf("frame%0d", u),
          {7'b0, frame_w[u]}, {7'b0, efr});
    end
  endtask

  task automatic set_digits(int a, int b, int c,
                            int d, int e, int f);
    bus.hrm  = 4'(a);
    bus.hrl  = 4'(b);
    bus.minm = 4'(c);
    bus.minl = 4'(d);
    bus.secm = 4'(e);
    bus.secl = 4'(f);
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    set_digits(1, 2, 3, 4, 5, 6);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_dark("reset");
    rst = 1'b0;

    repeat (2) tick();

    // Enable, then change secl while the hrl slot is lit.
    bus.en = 1'b1;
    repeat (6) tick();
    bus.secl = 4'd9;
    repeat (60) tick();

    // Leading-zero blank and dash.
    bus.hrm  = 4'd0;
    bus.minl = 4'hC;
    repeat (50) tick();

    // Enable drop mid-frame and restart.
    repeat (9) tick();
    bus.en = 1'b0;
    repeat (3) tick();
    set_digits(2, 3, 5, 9, 4, 7);
    bus.en = 1'b1;
    repeat (30) tick();

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_dark("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_dark("rst_hold");
    rst = 1'b0;
    repeat (30) tick();

    // Random digits and occasional enable toggles.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_digits($urandom_range(0, 2),
                   $urandom_range(0, 15),
                   $urandom_range(0, 15),
                   $urandom_range(0, 15),
                   $urandom_range(0, 15),
                   $urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0)
        bus.en = ~bus.en;
      tick();
    end

`ifdef RTC_SEG_BLINK_EN
    bus.en = 1'b1;
    repeat (3200) tick();
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
